// File: rtl/fpu_issue_scheduler.sv
// rtl/fpu_issue_scheduler.sv - single-issue FP scheduler with scoreboard and writeback-slot reservation
module fpu_issue_scheduler #(
   parameter int ADD_LAT = 3,
   parameter int MUL_LAT = 4,
   parameter int MAX_LAT = (ADD_LAT > MUL_LAT) ? ((ADD_LAT > 1) ? ADD_LAT : 1)
                                               : ((MUL_LAT > 1) ? MUL_LAT : 1)
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [6:0] req_opcode,
   input  logic [4:0] req_funct5,
   input  logic [1:0] req_fmt,
   input  logic [4:0] req_rd,
   input  logic [4:0] req_rs1,
   input  logic [4:0] req_rs2,
   output logic       add_start,
   output logic       add_sub,
   output logic       mul_start,
   output logic       misc_start,
   output logic       div_start,
   output logic       div_sqrt,
   input  logic       div_done,
   output logic       div_ack,
   output logic       wb_valid,
   output logic [4:0] wb_rd,
   output logic [1:0] wb_unit,
   output logic       illegal
);

   localparam logic [6:0] OP_FP  = 7'b1010011;
   localparam logic [1:0] FMT_H  = 2'b10;
   localparam logic [1:0] U_ADD  = 2'b00;
   localparam logic [1:0] U_MUL  = 2'b01;
   localparam logic [1:0] U_DIV  = 2'b10;
   localparam logic [1:0] U_MISC = 2'b11;

   typedef enum logic [1:0] {D_IDLE, D_BUSY, D_WAIT} div_state_t;

   div_state_t         d_state;
   logic [4:0]         div_rd;
   logic [31:0]        pending;
   // Index 0 is the writeback happening this cycle; index k is k cycles ahead.
   logic [MAX_LAT-1:0] wb_v;
   logic [4:0]         tag_rd   [MAX_LAT];
   logic [1:0]         tag_unit [MAX_LAT];

   logic       is_add, is_sub, is_mul, is_div, is_sqrt, is_misc;
   logic       legal, fixed, slot_busy, hazard, issue, div_wb;
   int         lat;
   logic [1:0] unit_sel;
   logic [31:0] set_mask, clr_mask;

   // Decode the operation into a target unit; anything unlisted is illegal.
   always_comb begin
      is_add  = 1'b0;
      is_sub  = 1'b0;
      is_mul  = 1'b0;
      is_div  = 1'b0;
      is_sqrt = 1'b0;
      is_misc = 1'b0;
      if (req_opcode == OP_FP && req_fmt == FMT_H) begin
         case (req_funct5)
            5'b00000: is_add = 1'b1;
            5'b00001: begin is_add = 1'b1; is_sub = 1'b1; end
            5'b00010: is_mul = 1'b1;
            5'b00011: is_div = 1'b1;
            5'b01011: begin is_div = 1'b1; is_sqrt = 1'b1; end
            5'b00100, 5'b00101, 5'b10100, 5'b11100: is_misc = 1'b1;
            default: ;
         endcase
      end
   end

   assign legal = is_add | is_mul | is_div | is_misc;
   assign fixed = is_add | is_mul | is_misc;

   // Latency and result-mux select of fixed-latency ops.
   always_comb begin
      lat      = 1;
      unit_sel = U_MISC;
      if (is_add) begin
         lat      = ADD_LAT;
         unit_sel = U_ADD;
      end else if (is_mul) begin
         lat      = MUL_LAT;
         unit_sel = U_MUL;
      end
   end

   // Slot t+L sits at index L now; L == MAX_LAT is beyond the window and always free.
   always_comb begin
      slot_busy = 1'b0;
      for (int i = 1; i < MAX_LAT; i++) begin
         if (fixed && i == lat) slot_busy = wb_v[i];
      end
   end

   assign hazard = pending[req_rd] | pending[req_rs1] | pending[req_rs2];

   // Ready depends only on state and request fields, never on req_valid.
   always_comb begin
      if (RST || d_state == D_WAIT)
         req_ready = 1'b0;
      else if (!legal)
         req_ready = 1'b1;
      else
         req_ready = !hazard && !slot_busy && !(is_div && d_state != D_IDLE);
   end

   assign issue      = req_valid & req_ready & legal;
   assign illegal    = req_valid & req_ready & ~legal;
   assign add_start  = issue & is_add;
   assign add_sub    = add_start & is_sub;
   assign mul_start  = issue & is_mul;
   assign misc_start = issue & is_misc;
   assign div_start  = issue & is_div;
   assign div_sqrt   = div_start & is_sqrt;

   // Fixed-latency writebacks win; the held div result drains in the first free cycle.
   assign div_wb   = (d_state == D_WAIT) & ~wb_v[0];
   assign div_ack  = div_wb;
   assign wb_valid = wb_v[0] | div_wb;
   assign wb_rd    = wb_v[0] ? tag_rd[0]   : (div_wb ? div_rd : 5'd0);
   assign wb_unit  = wb_v[0] ? tag_unit[0] : (div_wb ? U_DIV  : U_ADD);

   assign set_mask = issue    ? (32'd1 << req_rd) : 32'd0;
   assign clr_mask = wb_valid ? (32'd1 << wb_rd)  : 32'd0;

   // Scoreboard and writeback reservation/tag shift registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pending <= 32'd0;
         wb_v    <= '0;
         for (int i = 0; i < MAX_LAT; i++) begin
            tag_rd[i]   <= 5'd0;
            tag_unit[i] <= 2'b00;
         end
      end else begin
         pending <= (pending & ~clr_mask) | set_mask;
         for (int i = 0; i < MAX_LAT - 1; i++) begin
            wb_v[i]     <= wb_v[i+1];
            tag_rd[i]   <= tag_rd[i+1];
            tag_unit[i] <= tag_unit[i+1];
         end
         wb_v[MAX_LAT-1] <= 1'b0;
         if (issue && fixed) begin
            for (int i = 0; i < MAX_LAT; i++) begin
               if (i == lat - 1) begin
                  wb_v[i]     <= 1'b1;
                  tag_rd[i]   <= req_rd;
                  tag_unit[i] <= unit_sel;
               end
            end
         end
      end
   end

   // Div tracking: one outstanding div, result held by the unit until acked.
   always_ff @(posedge CLK) begin
      if (RST) begin
         d_state <= D_IDLE;
         div_rd  <= 5'd0;
      end else begin
         case (d_state)
            D_IDLE: if (issue && is_div) begin
               d_state <= D_BUSY;
               div_rd  <= req_rd;
            end
            D_BUSY: if (div_done) d_state <= D_WAIT;
            D_WAIT: if (!wb_v[0]) d_state <= D_IDLE;
            default: d_state <= D_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// tb/tb_fpu_issue_scheduler.sv - self-checking bench for fpu_issue_scheduler
module tb_fpu_issue_scheduler;

   localparam logic [6:0] FOP  = 7'b1010011;
   localparam logic [1:0] HALF = 2'b10;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [6:0] req_opcode = 7'd0;
   logic [4:0] req_funct5 = 5'd0;
   logic [1:0] req_fmt = 2'd0;
   logic [4:0] req_rd = 5'd0, req_rs1 = 5'd0, req_rs2 = 5'd0;
   logic       add_start, add_sub, mul_start, misc_start, div_start, div_sqrt;
   logic       div_done = 1'b0;
   logic       div_ack, wb_valid, illegal;
   logic [4:0] wb_rd;
   logic [1:0] wb_unit;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   fpu_issue_scheduler dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_funct5(req_funct5), .req_fmt(req_fmt),
      .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .add_start(add_start), .add_sub(add_sub), .mul_start(mul_start),
      .misc_start(misc_start), .div_start(div_start), .div_sqrt(div_sqrt),
      .div_done(div_done), .div_ack(div_ack),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_unit(wb_unit),
      .illegal(illegal)
   );

   typedef struct {
      logic [6:0] op;
      logic [4:0] f5;
      logic [1:0] fmt;
      logic [4:0] rd;
      logic       exp_ready;
      logic [3:0] exp_start;   // {add, mul, misc, div}
      logic       exp_sub;
      logic       exp_sqrt;
      logic       exp_ill;
      int         exp_lat;     // 0 = no writeback expected
      logic [1:0] exp_unit;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to the middle of the next cycle, apply inputs, let them settle.
   task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] f5,
                        input logic [1:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic done);
      @(negedge CLK);
      req_valid = v; req_opcode = op; req_funct5 = f5; req_fmt = fmt;
      req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; div_done = done;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 7'd0, 5'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_starts"}, {add_start, mul_start, misc_start, div_start}, 4'b0000);
      chk({tag, "_wb_valid"}, wb_valid, 1'b0);
      chk({tag, "_wb_rd"}, wb_rd, 5'd0);
      chk({tag, "_wb_unit"}, wb_unit, 2'b00);
      chk({tag, "_div_ack"}, div_ack, 1'b0);
      chk({tag, "_illegal"}, illegal, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1; req_valid = 1'b0; div_done = 1'b0;
      req_opcode = FOP; req_funct5 = 5'b00000; req_fmt = HALF;
      req_rd = 5'd1; req_rs1 = 5'd2; req_rs2 = 5'd3;
      #1;
      chk("rst_ready", req_ready, 1'b0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk_quiet("rst");
   endtask

   initial begin
      vecs[0]  = '{FOP, 5'b00000, HALF, 5'd3,  1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 3, 2'b00};
      vecs[1]  = '{FOP, 5'b00001, HALF, 5'd4,  1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 3, 2'b00};
      vecs[2]  = '{FOP, 5'b00010, HALF, 5'd5,  1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4, 2'b01};
      vecs[3]  = '{FOP, 5'b00011, HALF, 5'd6,  1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 0, 2'b00};
      vecs[4]  = '{FOP, 5'b01011, HALF, 5'd7,  1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 0, 2'b00};
      vecs[5]  = '{FOP, 5'b00100, HALF, 5'd8,  1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1, 2'b11};
      vecs[6]  = '{FOP, 5'b00101, HALF, 5'd9,  1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1, 2'b11};
      vecs[7]  = '{FOP, 5'b10100, HALF, 5'd10, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1, 2'b11};
      vecs[8]  = '{FOP, 5'b11100, HALF, 5'd11, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1, 2'b11};
      vecs[9]  = '{7'b1000011, 5'b00000, HALF, 5'd12, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 2'b00};
      vecs[10] = '{FOP, 5'b00000, 2'b00, 5'd13, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 2'b00};
      vecs[11] = '{FOP, 5'b11010, HALF, 5'd14, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 2'b00};
      vecs[12] = '{FOP, 5'b00110, HALF, 5'd15, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 2'b00};

      // Table: one op from reset, check decode then the writeback window.
      for (int n = 0; n < 13; n++) begin
         do_reset();
         drive(1'b1, vecs[n].op, vecs[n].f5, vecs[n].fmt, vecs[n].rd, 5'd20, 5'd21, 1'b0);
         chk($sformatf("v%0d_ready", n), req_ready, vecs[n].exp_ready);
         chk($sformatf("v%0d_start", n), {add_start, mul_start, misc_start, div_start},
             vecs[n].exp_start);
         chk($sformatf("v%0d_illegal", n), illegal, vecs[n].exp_ill);
         if (vecs[n].exp_start[3]) chk($sformatf("v%0d_add_sub", n), add_sub, vecs[n].exp_sub);
         if (vecs[n].exp_start[0]) chk($sformatf("v%0d_div_sqrt", n), div_sqrt, vecs[n].exp_sqrt);
         for (int k = 1; k <= 5; k++) begin
            idle();
            chk($sformatf("v%0d_wb_valid_k%0d", n, k), wb_valid, (k == vecs[n].exp_lat));
            chk($sformatf("v%0d_illegal_k%0d", n, k), illegal, 1'b0);
            if (k == vecs[n].exp_lat) begin
               chk($sformatf("v%0d_wb_rd", n), wb_rd, vecs[n].rd);
               chk($sformatf("v%0d_wb_unit", n), wb_unit, vecs[n].exp_unit);
            end
         end
      end

      // Writeback collision: FMUL rd1 then FADD rd2 one cycle later.
      do_reset();
      drive(1'b1, FOP, 5'b00010, HALF, 5'd1, 5'd10, 5'd11, 1'b0);
      chk("col_mul_start", mul_start, 1'b1);
      drive(1'b1, FOP, 5'b00000, HALF, 5'd2, 5'd10, 5'd11, 1'b0);
      chk("col_ready_t1", req_ready, 1'b0);
      chk("col_add_start_t1", add_start, 1'b0);
      drive(1'b1, FOP, 5'b00000, HALF, 5'd2, 5'd10, 5'd11, 1'b0);
      chk("col_ready_t2", req_ready, 1'b1);
      chk("col_add_start_t2", add_start, 1'b1);
      idle();
      chk("col_wb_t3", wb_valid, 1'b0);
      idle();
      chk("col_wb_t4", wb_valid, 1'b1);
      chk("col_wb_rd_t4", wb_rd, 5'd1);
      chk("col_wb_unit_t4", wb_unit, 2'b01);
      idle();
      chk("col_wb_t5", wb_valid, 1'b1);
      chk("col_wb_rd_t5", wb_rd, 5'd2);
      chk("col_wb_unit_t5", wb_unit, 2'b00);

      // RAW stall: FADD rd5, then FMUL reading rs1=5.
      do_reset();
      drive(1'b1, FOP, 5'b00000, HALF, 5'd5, 5'd20, 5'd21, 1'b0);
      chk("raw_add_start", add_start, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         drive(1'b1, FOP, 5'b00010, HALF, 5'd6, 5'd5, 5'd21, 1'b0);
         chk($sformatf("raw_ready_c%0d", c), req_ready, 1'b0);
         chk($sformatf("raw_mul_start_c%0d", c), mul_start, 1'b0);
         if (c == 3) begin
            chk("raw_wb_valid_c3", wb_valid, 1'b1);
            chk("raw_wb_rd_c3", wb_rd, 5'd5);
         end
      end
      drive(1'b1, FOP, 5'b00010, HALF, 5'd6, 5'd5, 5'd21, 1'b0);
      chk("raw_ready_c4", req_ready, 1'b1);
      chk("raw_mul_start_c4", mul_start, 1'b1);
      drive(1'b1, FOP, 5'b00100, HALF, 5'd9, 5'd20, 5'd6, 1'b0);
      chk("raw_rs2_ready", req_ready, 1'b0);
      chk("raw_rs2_misc_start", misc_start, 1'b0);

      // Div arbitration against a fixed-latency writeback.
      do_reset();
      drive(1'b1, FOP, 5'b00011, HALF, 5'd7, 5'd20, 5'd21, 1'b0);
      chk("div_start_c0", div_start, 1'b1);
      chk("div_sqrt_c0", div_sqrt, 1'b0);
      for (int c = 1; c <= 17; c++) begin
         if (c == 5) begin
            drive(1'b1, FOP, 5'b01011, HALF, 5'd9, 5'd20, 5'd21, 1'b0);
            chk("div_second_ready", req_ready, 1'b0);
            chk("div_second_start", div_start, 1'b0);
         end else begin
            idle();
         end
      end
      drive(1'b1, FOP, 5'b00000, HALF, 5'd8, 5'd20, 5'd21, 1'b0);
      chk("div_add_ready_c18", req_ready, 1'b1);
      chk("div_add_start_c18", add_start, 1'b1);
      idle();
      drive(1'b0, 7'd0, 5'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1);
      chk("div_wb_c20", wb_valid, 1'b0);
      drive(1'b0, FOP, 5'b00010, HALF, 5'd12, 5'd7, 5'd21, 1'b0);
      chk("div_ready_c21", req_ready, 1'b0);
      chk("div_wb_c21", wb_valid, 1'b1);
      chk("div_wb_rd_c21", wb_rd, 5'd8);
      chk("div_wb_unit_c21", wb_unit, 2'b00);
      chk("div_ack_c21", div_ack, 1'b0);
      drive(1'b0, FOP, 5'b00010, HALF, 5'd12, 5'd7, 5'd21, 1'b0);
      chk("div_ready_c22", req_ready, 1'b0);
      chk("div_wb_c22", wb_valid, 1'b1);
      chk("div_wb_rd_c22", wb_rd, 5'd7);
      chk("div_wb_unit_c22", wb_unit, 2'b10);
      chk("div_ack_c22", div_ack, 1'b1);
      drive(1'b0, FOP, 5'b00010, HALF, 5'd12, 5'd7, 5'd21, 1'b0);
      chk("div_ready_c23", req_ready, 1'b1);
      chk("div_wb_c23", wb_valid, 1'b0);
      chk("div_ack_c23", div_ack, 1'b0);

      // Reset while the div is busy; the late div_done must be ignored.
      do_reset();
      drive(1'b1, FOP, 5'b00011, HALF, 5'd4, 5'd20, 5'd21, 1'b0);
      chk("rmd_div_start", div_start, 1'b1);
      for (int c = 1; c <= 9; c++) idle();
      drive(1'b0, FOP, 5'b00000, HALF, 5'd1, 5'd2, 5'd3, 1'b0);
      RST = 1'b1;
      #1;
      chk("rmd_ready_c10", req_ready, 1'b0);
      idle();
      RST = 1'b0;
      #1;
      chk_quiet("rmd_c11");
      drive(1'b0, 7'd0, 5'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1);
      chk("rmd_wb_c12", wb_valid, 1'b0);
      drive(1'b1, FOP, 5'b01011, HALF, 5'd4, 5'd20, 5'd21, 1'b0);
      chk("rmd_ready_c13", req_ready, 1'b1);
      chk("rmd_div_start_c13", div_start, 1'b1);
      chk("rmd_div_sqrt_c13", div_sqrt, 1'b1);
      for (int c = 14; c <= 16; c++) begin
         idle();
         chk($sformatf("rmd_wb_c%0d", c), wb_valid, 1'b0);
         chk($sformatf("rmd_ack_c%0d", c), div_ack, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fpu_issue_scheduler.md
# fpu_issue_scheduler

Single-issue scheduler that sits between the FP instruction dispatcher and the half-precision FPU execution units. It decodes each incoming FP operation and starts exactly one unit: add/sub, multiply, iterative div/sqrt, or single-cycle misc (sgnj/minmax/compare/classify). It holds a scoreboard of pending destination registers. It also reserves the single shared writeback port so that two results never collide.

## Interface
- ADD_LAT, 3, fixed add/sub pipeline latency in cycles (≥1)
- MUL_LAT, 4, fixed multiply pipeline latency in cycles (≥1)
- MAX_LAT, max(ADD_LAT,MUL_LAT,1), depth of the writeback reservation and tag shift registers
- CLK  in  1  clock, all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  1  dispatcher presents an operation
- req_ready  out  1  scheduler accepts the operation this cycle (combinational)
- req_opcode  in  7  instruction opcode
- req_funct5  in  5  funct5 field
- req_fmt  in  2  fmt field
- req_rd, req_rs1, req_rs2  in  5 each  destination and source FP register indices
- add_start  out  1  start pulse to the add unit
- add_sub  out  1  1 = FSUB, qualified by add_start
- mul_start  out  1  start pulse to the multiply unit
- misc_start  out  1  start pulse to the misc unit
- div_start  out  1  start pulse to the div/sqrt unit
- div_sqrt  out  1  1 = FSQRT, qualified by div_start
- div_done  in  1  one-cycle pulse from div unit; the unit holds its result until div_ack
- div_ack  out  1  div result consumed
- wb_valid  out  1  writeback this cycle
- wb_rd  out  5  writeback destination
- wb_unit  out  2  result mux select: 00 add, 01 mul, 10 div, 11 misc
- illegal  out  1  one-cycle pulse for an unsupported operation

## Operation
- **Handshake:** accepted when req_valid & req_ready at the rising edge, called cycle t. Start outputs are driven combinationally in cycle t.
- **Decode:**
  - A request is legal only with opcode 1010011 (FOP) and fmt 10 (half).
  - funct5 00000 → add (add_sub=0); 00001 → add (add_sub=1); 00010 → mul.
  - funct5 00011 → div (div_sqrt=0); 01011 → div (div_sqrt=1).
  - funct5 00100, 00101, 10100, 11100 → misc, latency 1.
  - Anything else is illegal.
  - No FCVT support; funct5 00000 is always FADD.
- **Illegal:** req_ready=1. illegal pulses in cycle t. No start, no scoreboard change, no writeback.
- **Scoreboard:** 32-bit pending mask.
  - Set bit rd at the handshake. Clear bit wb_rd on the edge closing a wb_valid cycle.
  - Stall (req_ready=0) if rd, rs1 or rs2 is pending in the registered mask. rs2 is checked for all ops.
  - No bypass: a register written back in cycle c may be reissued against from cycle c+1.
- **Writeback reservation:** a fixed-latency op of latency L needs the slot at t+L free; otherwise stall. Its result is drained as wb_valid in cycle t+L, with wb_rd/wb_unit taken from a parallel tag shift register.
- **Div FSM (one div outstanding):**
  - D_IDLE: div handshake → D_BUSY.
  - D_BUSY: div_done → D_WAIT. Further div requests stall; other ops may issue.
  - D_WAIT: req_ready=0 for all requests. In the first cycle with no fixed-latency writeback, drive wb_valid=1, wb_unit=10, wb_rd=div tag, div_ack=1, and go to D_IDLE.
  - Fixed-latency writebacks always take priority. Wait is bounded by MAX_LAT cycles because issue is frozen.
- **Ignored input:** div_done in D_IDLE or D_WAIT is ignored.

## Timing
- **Reset:**
  - req_ready=0, all start outputs, div_ack, wb_valid, illegal = 0.
  - wb_rd=0, wb_unit=00.
  - Scoreboard, reservations and tags cleared; FSM=D_IDLE.
- **Reset mid-operation:** all in-flight results are discarded. Units may finish, but no wb_valid is produced for them.
- **Latency:**
  - add: wb at t+ADD_LAT. mul: wb at t+MUL_LAT. misc: wb at t+1.
  - div: wb at the first free cycle ≥ (div_done cycle)+1.
- **Throughput:** at most one issue and one writeback per cycle.
- **Same-cycle events:**
  - An issue in cycle c may target a slot freed by that cycle's writeback.
  - An issue and div_done may occur in the same cycle.
- **Ready:** req_ready is combinational from state and request fields only; it is never a function of req_valid.

## Test plan
- **Basic add:** FADD rd=3 accepted at cycle 0 → add_start=1, add_sub=0 at cycle 0; wb_valid=1, wb_rd=3, wb_unit=00 at cycle 3; scoreboard bit 3 clear from cycle 4.
- **Writeback collision:** FMUL rd=1 at t, then FADD rd=2 offered at t+1 (both would write back at t+4) → req_ready=0 at t+1; FADD issues t+2; writebacks at t+4 (mul) and t+5 (add).
- **RAW stall:** FADD rd=5 at cycle 0, then FMUL rs1=5 → req_ready=0 in cycles 1-3; FMUL accepted at cycle 4.
- **Div arbitration:** FDIV rd=7 at cycle 0, FADD rd=8 at cycle 18, div_done at cycle 20 → add wb cycle 21; div wb_valid/div_ack cycle 22 with wb_unit=10, wb_rd=7; req_ready=0 in cycles 21-22.
- **Illegal ops:** opcode 1000011 (FMADD), or FOP with fmt=00 → req_ready=1, illegal pulse one cycle, no start, no wb.
- **Reset mid-div:** RST in cycle 10 while in D_BUSY → all outputs 0 at cycle 11; div_done at cycle 12 ignored; wb_valid stays 0; a new FSQRT is accepted at cycle 13.
